// File: rtl/mul_unit.sv
// -----------------------------------------------------------------------------
// mul_unit -- iterative 32x32 radix-2 shift-add multiplier for RV32M
// (MUL, MULH, MULHSU, MULHU). It sits beside the EX-stage ALU and holds the
// pipeline with `stall` until the product is ready.
//
// Ports:
//   clk     in   pipeline clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   request to begin a multiply (ALU multiply flag & EX-valid)
//   funct3  in   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; funct3[2]=1 ignored
//   x1      in   multiplicand
//   x2      in   multiplier
//   flush   in   synchronous kill, forces IDLE on the next edge
//   stall   out  combinational pipeline freeze
//   busy    out  high whenever the FSM is not IDLE
//   done    out  one-cycle pulse, result valid while high
//   result  out  registered product word (low for MUL, high otherwise)
//
// Latency: start sampled at edge k, 32 iterations on edges k+1..k+32, the
// sign fix-up on edge k+33 enters DONE, so done is high after edge k+33.
// -----------------------------------------------------------------------------
module mul_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;
  // High half is the running accumulator, low half starts as the multiplier
  // and is shifted out one bit per iteration as product bits shift in.
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [4:0]          count_q, count_d;
  logic                neg_q, neg_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                x1_signed_s;
  logic                x2_signed_s;
  logic                accept_s;
  logic [XLEN:0]       sum_s;
  logic [2*XLEN-1:0]   prod_fix_s;

  // Absolute value of an operand; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude 2^31.
  function automatic logic [31:0] magnitude(input logic [31:0] v,
                                            input logic        is_signed);
    logic [31:0] m;
    if (is_signed && v[31]) begin
      m = ~v + 32'd1;
    end else begin
      m = v;
    end
    return m;
  endfunction

  assign x1_signed_s = (funct3 != 3'b011);
  assign x2_signed_s = (funct3[2:1] == 2'b00);
  assign accept_s    = (state_q == S_IDLE) & start & ~funct3[2] & ~flush;

  // One shift-add step: conditional add of the multiplicand with carry out.
  always_comb begin
    sum_s = {1'b0, prod_q[2*XLEN-1:XLEN]};
    if (prod_q[0]) begin
      sum_s = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
    end else begin
      sum_s = {1'b0, prod_q[2*XLEN-1:XLEN]};
    end
  end

  // Two's-complement fix-up of the unsigned product when the signs differ.
  always_comb begin
    prod_fix_s = prod_q;
    if (neg_q) begin
      prod_fix_s = ~prod_q + 64'd1;
    end else begin
      prod_fix_s = prod_q;
    end
  end

  // Next-state and datapath update; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    count_d  = count_q;
    neg_d    = neg_q;
    op_d     = op_q;
    result_d = result_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            mcand_d = magnitude(x1, x1_signed_s);
            prod_d  = {32'd0, magnitude(x2, x2_signed_s)};
            neg_d   = (x1_signed_s & x1[31]) ^ (x2_signed_s & x2[31]);
            op_d    = funct3;
            count_d = 5'd0;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          prod_d  = {sum_s, prod_q[XLEN-1:1]};
          count_d = count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_d = S_SIGN;
          end else begin
            state_d = S_RUN;
          end
        end
        S_SIGN: begin
          prod_d  = prod_fix_s;
          if (op_q == 3'b000) begin
            result_d = prod_fix_s[XLEN-1:0];
          end else begin
            result_d = prod_fix_s[2*XLEN-1:XLEN];
          end
          state_d = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= 32'd0;
      prod_q   <= 64'd0;
      count_q  <= 5'd0;
      neg_q    <= 1'b0;
      op_q     <= 3'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  // stall is gated by rst_n so it reads 0 throughout reset even if start
  // happens to be high.
  assign stall  = rst_n & (accept_s | (state_q == S_RUN) | (state_q == S_SIGN));
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mul_unit.sv
module tb_mul_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total  = 0;
  int passed = 0;
  logic [31:0] last_res;

  mul_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .x1     (x1),
    .x2     (x2),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; returns at a negedge one cycle after done.
  task automatic run_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit hold, input string name);
    int   cyc;
    bit   seen;
    bit   stall_ok;
    logic stall_at_done;
    logic busy_at_done;
    funct3 = f3; x1 = a; x2 = b; start = 1'b1;
    #1;
    check({name, "_stall_issue"}, {31'd0, stall}, 32'd1);
    cyc = 0; seen = 1'b0; stall_ok = 1'b1;
    stall_at_done = 1'b1; busy_at_done = 1'b0;
    while (!seen && cyc < 60) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1'b1;
        stall_at_done = stall;
        busy_at_done  = busy;
      end else if (!stall) begin
        stall_ok = 1'b0;
      end
      if (hold && !seen) begin
        x1 = $urandom;
        x2 = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({name, "_latency"}, seen ? cyc : 32'hFFFF_FFFF, 32'd34);
    check({name, "_result"}, result, exp);
    check({name, "_stall_held"}, {31'd0, stall_ok}, 32'd1);
    check({name, "_stall_done"}, {31'd0, stall_at_done}, 32'd0);
    check({name, "_busy_done"}, {31'd0, busy_at_done}, 32'd1);
    @(negedge clk);
    check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    last_res = exp;
  endtask

  initial begin
    int  cnt;
    logic saw;

    //         funct3   x1            x2            expected
    vecs[0]  = '{3'b000, 32'd7,        32'd6,        32'h0000_002A};
    vecs[1]  = '{3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[2]  = '{3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[4]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[6]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[7]  = '{3'b011, 32'h8000_0000, 32'd2,        32'h0000_0001};
    vecs[8]  = '{3'b000, 32'h1234_5678, 32'h10,       32'h2345_6780};
    vecs[9]  = '{3'b010, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF};
    vecs[10] = '{3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
    vecs[11] = '{3'b000, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFF1};

    rst_n = 1'b0; start = 1'b0; funct3 = 3'd0; x1 = 32'd0; x2 = 32'd0; flush = 1'b0;
    last_res = 32'd0;
    #12;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors, issued back to back
    for (int i = 0; i < 12; i++) begin
      run_mul(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, $sformatf("v%0d", i));
    end

    // start held high with changing operands: only the first pair counts
    run_mul(3'b000, 32'd7, 32'd6, 32'h0000_002A, 1'b1, "hold");

    // Flush at iteration 10
    funct3 = 3'b000; x1 = 32'h1234; x2 = 32'h5678; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_stall", {31'd0, stall}, 32'd0);
    saw = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    check("flush_no_done", {31'd0, saw}, 32'd0);
    check("flush_result_kept", result, last_res);

    // Flush together with start in IDLE
    funct3 = 3'b000; x1 = 32'd9; x2 = 32'd9; start = 1'b1; flush = 1'b1;
    #1;
    check("flush_start_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'd0, busy}, 32'd0);

    // Divide opcode is ignored
    funct3 = 3'b100; x1 = 32'd100; x2 = 32'd7; start = 1'b1;
    #1;
    check("div_stall", {31'd0, stall}, 32'd0);
    saw = 1'b0; cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) saw = 1'b1;
      if (busy || stall) cnt++;
    end
    start = 1'b0;
    check("div_no_done", {31'd0, saw}, 32'd0);
    check("div_never_busy", cnt, 32'd0);

    // Asynchronous reset mid-RUN
    funct3 = 3'b000; x1 = 32'd11; x2 = 32'd13; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_stall", {31'd0, stall}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_mul(3'b000, 32'd3, 32'd5, 32'h0000_000F, 1'b0, "post_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
